// File: rtl/ls161.sv
// Synchronous 4-bit binary counter with LS161/LS163 clear behaviour.
// The cp pin is sampled on clk; a rising edge of cp advances the counter.
module ls161 #(
    parameter bit         ASYNC_CLEAR = 1'b1,
    parameter logic [3:0] RESET_VALUE = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cp,
    input  logic       mr_n,
    input  logic       pe_n,
    input  logic       cep,
    input  logic       cet,
    input  logic [3:0] p,
    output logic [3:0] q,
    output logic       tc
);

    logic       cp_q;
    logic       cp_rise;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign cp_rise = cp & ~cp_q;

    // LS161 clear bypasses the cp edge; LS163 clear waits for it.
    always_comb begin
        cnt_d = cnt_q;
        if (!mr_n && (ASYNC_CLEAR || cp_rise)) begin
            cnt_d = '0;
        end else if (cp_rise) begin
            if (!pe_n) begin
                cnt_d = p;
            end else if (cep && cet) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // cp_q is forced high in reset so a cp held high through release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= RESET_VALUE;
            cp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            cp_q  <= cp;
        end
    end

    assign q  = cnt_q;
    assign tc = cet & (&cnt_q);

endmodule

// File: tb/tb_ls161.sv
// Scoreboard bench for ls161: LS161 and LS163 variants on shared stimulus,
// plus a two-stage cascade checked as an 8-bit pulse counter.
module tb_ls161;

    localparam logic [3:0] RV_A = 4'h0;
    localparam logic [3:0] RV_S = 4'h3;

    logic       clk = 1'b0;
    logic       rst = 1'b1, cp = 1'b0, mr_n = 1'b1, pe_n = 1'b1, cep = 1'b1, cet = 1'b1;
    logic [3:0] p = 4'h0;
    logic       crst = 1'b1, ccp = 1'b0;

    logic       n_rst = 1'b1, n_cp = 1'b0, n_mr = 1'b1, n_pe = 1'b1, n_cep = 1'b1, n_cet = 1'b1;
    logic [3:0] n_p = 4'h0;
    logic       n_crst = 1'b1, n_ccp = 1'b0;

    logic [3:0] qa, qs, q0, q1;
    logic       ta, ts, tc0, tc1;

    always #5 clk = ~clk;

    ls161 #(.ASYNC_CLEAR(1'b1), .RESET_VALUE(RV_A)) dut_a (
        .clk(clk), .reset(rst), .cp(cp), .mr_n(mr_n), .pe_n(pe_n),
        .cep(cep), .cet(cet), .p(p), .q(qa), .tc(ta));

    ls161 #(.ASYNC_CLEAR(1'b0), .RESET_VALUE(RV_S)) dut_s (
        .clk(clk), .reset(rst), .cp(cp), .mr_n(mr_n), .pe_n(pe_n),
        .cep(cep), .cet(cet), .p(p), .q(qs), .tc(ts));

    ls161 #(.ASYNC_CLEAR(1'b1), .RESET_VALUE(4'h0)) c0 (
        .clk(clk), .reset(crst), .cp(ccp), .mr_n(1'b1), .pe_n(1'b1),
        .cep(1'b1), .cet(1'b1), .p(4'h0), .q(q0), .tc(tc0));

    ls161 #(.ASYNC_CLEAR(1'b1), .RESET_VALUE(4'h0)) c1 (
        .clk(clk), .reset(crst), .cp(ccp), .mr_n(1'b1), .pe_n(1'b1),
        .cep(1'b1), .cet(tc0), .p(4'h0), .q(q1), .tc(tc1));

    typedef struct {
        logic [3:0] qa;
        logic       ta;
        logic [3:0] qs;
        logic       ts;
        logic [7:0] cb;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    string phase = "init";

    // Reference state: counter values and last seen cp level per chip clock.
    int   m_a, m_s, m_byte;
    bit   m_prev, m_cprev;

    function automatic int next_val(int cur, bit async_clr, bit rise);
        if (!mr_n && (async_clr || rise)) return 0;
        if (!rise) return cur;
        if (!pe_n) return int'(p);
        if (cep && cet) return (cur + 1) % 16;
        return cur;
    endfunction

    task automatic tick();
        exp_t e;
        bit   rise, crise;
        @(negedge clk);
        rst = n_rst; cp = n_cp; mr_n = n_mr; pe_n = n_pe;
        cep = n_cep; cet = n_cet; p = n_p; crst = n_crst; ccp = n_ccp;
        rise  = cp && !m_prev;
        crise = ccp && !m_cprev;
        if (rst) begin
            m_a = int'(RV_A); m_s = int'(RV_S); m_prev = 1'b1;
        end else begin
            m_a = next_val(m_a, 1'b1, rise);
            m_s = next_val(m_s, 1'b0, rise);
            m_prev = cp;
        end
        if (crst) begin
            m_byte = 0; m_cprev = 1'b1;
        end else begin
            if (crise) m_byte = (m_byte + 1) % 256;
            m_cprev = ccp;
        end
        e.qa = 4'(m_a); e.ta = cet && (m_a == 15);
        e.qs = 4'(m_s); e.ts = cet && (m_s == 15);
        e.cb = 8'(m_byte);
        e.tag = phase;
        sb.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse();
        n_cp = 1'b1; tick();
        n_cp = 1'b0; tick();
    endtask

    task automatic cpulse();
        n_ccp = 1'b1; tick();
        n_ccp = 1'b0; tick();
    endtask

    task automatic chk(input string name, input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%s]: got %h expected %h at %0t", name, tag, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ls161_q_tc", e.tag, {3'b0, ta, qa}, {3'b0, e.ta, e.qa});
                chk("ls163_q_tc", e.tag, {3'b0, ts, qs}, {3'b0, e.ts, e.qs});
                chk("cascade_byte", e.tag, {q1, q0}, e.cb);
            end
        end
    end

    initial begin : stim
        int wait_cycles;
        // Reset with cp toggling, released while cp is high.
        phase = "reset";
        n_rst = 1'b1; n_crst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cp = ~n_cp; n_ccp = ~n_ccp; tick();
        end
        n_cp = 1'b1; n_ccp = 1'b1; tick();
        n_rst = 1'b0; n_crst = 1'b0;
        ticks(2);
        n_cp = 1'b0; n_ccp = 1'b0; tick();

        // 16 counting pulses with wrap and tc at F.
        phase = "count16";
        for (int i = 0; i < 16; i++) pulse();

        // Load has priority over counting.
        phase = "load";
        n_pe = 1'b0; n_p = 4'h5; pulse();
        n_p = 4'hA; n_cep = 1'b0; pulse();
        n_p = 4'h5; n_cep = 1'b1; pulse();
        n_p = 4'hA; pulse();
        n_pe = 1'b1;

        // Clear with cp held low, then a cp rise.
        phase = "clear";
        n_pe = 1'b0; n_p = 4'h7; pulse();
        n_pe = 1'b1;
        n_mr = 1'b0; ticks(3);
        pulse();
        n_mr = 1'b1; ticks(2);

        // cp held high for many clk cycles counts once per period.
        phase = "cp_hold";
        n_cp = 1'b1; ticks(10);
        n_cp = 1'b0; ticks(2);
        n_cp = 1'b1; ticks(3);
        n_cp = 1'b0; tick();

        // cet gating of count and tc at q=F.
        phase = "cet_gate";
        n_pe = 1'b0; n_p = 4'hF; pulse();
        n_pe = 1'b1; tick();
        n_cet = 1'b0; tick();
        pulse();
        n_cet = 1'b1; tick();
        pulse();

        // Cascade: 256 pulses wrap the byte, then reset mid-count at 0x3C.
        phase = "cascade";
        for (int i = 0; i < 256; i++) cpulse();
        for (int i = 0; i < 16'h3C; i++) cpulse();
        phase = "casc_reset";
        n_crst = 1'b1; n_ccp = 1'b1; tick();
        n_ccp = 1'b0; tick();
        n_crst = 1'b0; ticks(2);
        cpulse(); cpulse();

        // Randomized traffic on all inputs.
        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) n_cp = ~n_cp;
            if ($urandom_range(0, 1) == 0) n_ccp = ~n_ccp;
            n_mr  = ($urandom_range(0, 11) != 0);
            n_pe  = ($urandom_range(0, 7) != 0);
            n_cep = ($urandom_range(0, 5) != 0);
            n_cet = ($urandom_range(0, 5) != 0);
            n_p   = 4'($urandom_range(0, 15));
            n_rst = ($urandom_range(0, 99) == 0);
            n_crst = ($urandom_range(0, 199) == 0);
            tick();
        end
        n_rst = 1'b0; n_crst = 1'b0;

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
